multibyte_serial_adder: RTL and testbench

MULTIBYTE_SERIAL_ADDER -- requirements
Module: multibyte_serial_adder

---
 rtl/multibyte_serial_adder.sv | 105 ++++++++++
 tb/tb_multibyte_serial_adder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/multibyte_serial_adder.sv
// Byte-serial adder: captures two NBYTES-wide operands plus carry-in, adds one
// byte per cycle with a rippled registered carry, then publishes SUM/CO with a DONE pulse.
module multibyte_serial_adder #(
  parameter int NBYTES = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [8*NBYTES-1:0]   A,
  input  logic [8*NBYTES-1:0]   B,
  input  logic                  CI,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [8*NBYTES-1:0]   SUM,
  output logic                  CO
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [NBYTES-1:0][7:0]   a_q, a_d;
  logic [NBYTES-1:0][7:0]   b_q, b_d;
  logic [NBYTES-1:0][7:0]   part_q, part_d;
  logic [8*NBYTES-1:0]      sum_q, sum_d;
  logic                     co_q, co_d;
  logic                     carry_q, carry_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [8:0]               byte_sum;

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch can infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    part_d   = part_q;
    sum_d    = sum_q;
    co_d     = co_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    byte_sum = {1'b0, a_q[idx_q]} + {1'b0, b_q[idx_q]} + {8'd0, carry_q};

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          carry_d = CI;
          idx_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        part_d[idx_q] = byte_sum[7:0];
        carry_d       = byte_sum[8];
        if (idx_q == LAST_IDX) begin
          // The final byte goes straight into SUM, bypassing the partial register.
          sum_d   = part_d;
          co_d    = byte_sum[8];
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  assign BUSY = (state_q == S_ADD);
  assign DONE = (state_q == S_DONE);
  assign SUM  = sum_q;
  assign CO   = co_q;

endmodule

// File: tb/tb_multibyte_serial_adder.sv
// Bench for multibyte_serial_adder (NBYTES=4): directed operations with literal
// expectations plus an arithmetic reference model compared on every cycle.
module tb_multibyte_serial_adder;

  localparam int N = 4;
  localparam int W = 8 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         ci_in;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         co;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  multibyte_serial_adder #(.NBYTES(N)) dut (
    .CLK   (clk),
    .RST   (rst),
    .START (start),
    .A     (a_in),
    .B     (b_in),
    .CI    (ci_in),
    .BUSY  (busy),
    .DONE  (done),
    .SUM   (sum),
    .CO    (co)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request resolves to A+B+CI, published after N busy cycles.
  int           m_cnt = 0;
  logic [W:0]   m_res = '0;
  logic [W-1:0] m_sum = '0;
  logic         m_co  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0;
      m_sum = '0;
      m_co  = 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_cnt = 1;
        m_res = {1'b0, a_in} + {1'b0, b_in} + {{W{1'b0}}, ci_in};
      end
    end else if (m_cnt == N) begin
      m_cnt = N + 1;
      m_sum = m_res[W-1:0];
      m_co  = m_res[W];
    end else if (m_cnt == N + 1) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", 64'(busy), 64'(m_cnt >= 1 && m_cnt <= N));
      check("model_done", 64'(done), 64'(m_cnt == N + 1));
      check("model_sum",  64'(sum),  64'(m_sum));
      check("model_co",   64'(co),   64'(m_co));
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic [W-1:0] exp_sum, input logic exp_co, input bit scramble);
    int lat;
    bit got;
    a_in  = a;
    b_in  = b;
    ci_in = ci;
    start = 1'b1;
    lat   = 0;
    got   = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (scramble && busy) begin
        a_in  = $urandom;
        b_in  = $urandom;
        ci_in = 1'($urandom_range(0, 1));
      end
      if (done) begin
        lat = i;
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("done_timeout", 64'd0, 64'd1);
    end else begin
      check("latency", 64'(lat), 64'(N + 1));
      check("lit_sum", 64'(sum), 64'(exp_sum));
      check("lit_co",  64'(co),  64'(exp_co));
    end
    @(negedge clk);
  endtask

  initial begin
    int pulses;
    int prev;
    int dn;

    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    ci_in = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum",  64'(sum),  64'd0);
    check("rst_co",   64'(co),   64'd0);

    // First START coincides with the first edge that has reset released.
    rst = 1'b0;
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0);
    run_op(32'h80FF_7FFF, 32'h8000_0001, 1'b0, 32'h00FF_8000, 1'b1, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);

    // START held high: back-to-back operations, operands drift every cycle.
    a_in   = 32'h0102_0304;
    b_in   = 32'h0000_0010;
    ci_in  = 1'b0;
    start  = 1'b1;
    pulses = 0;
    prev   = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (prev >= 0) check("pulse_gap", 64'(i - prev), 64'd6);
        prev = i;
      end
      a_in = a_in + 32'h0101_0101;
    end
    start = 1'b0;
    check("pulse_count", 64'(pulses), 64'd3);
    repeat (8) @(negedge clk);

    // Reset at the third edge of an operation aborts it.
    a_in  = 32'hDEAD_BEEF;
    b_in  = 32'h0BAD_F00D;
    ci_in = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_sum",  64'(sum),  64'd0);
    check("abort_co",   64'(co),   64'd0);
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("no_done_after_abort", 64'(dn), 64'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
